// File: rtl/operand_stage_pkg.sv
// Shared constants, execute-bundle type and index helpers for the operand stage.
package operand_stage_pkg;

    localparam int OS_DATA_W = 32;
    localparam int OS_REG_AW = 4;
    localparam int OS_CTRL_W = 8;
    localparam int OS_NREG   = 16;

    localparam logic [3:0] REG_ZERO = 4'h0;
    localparam logic [3:0] REG_PC   = 4'hF;

    // R0 and PC never carry a pending write.
    localparam logic [OS_NREG-1:0] TRACK_MASK = 16'h7FFE;

    typedef struct packed {
        logic [OS_DATA_W-1:0] op_a;
        logic [OS_DATA_W-1:0] op_b;
        logic [OS_REG_AW-1:0] rd;
        logic                 we;
        logic [OS_CTRL_W-1:0] ctrl;
    } ex_bundle_t;

    function automatic logic is_tracked(input logic [OS_REG_AW-1:0] idx);
        return (idx != REG_ZERO) && (idx != REG_PC);
    endfunction

    function automatic logic [OS_NREG-1:0] reg_onehot(input logic [OS_REG_AW-1:0] idx);
        return OS_NREG'(1) << idx;
    endfunction

endpackage

// File: rtl/operand_stage_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set on issue,
// cleared on writeback retire or flush. Exposes the retire-adjusted view.
module operand_scoreboard
    import operand_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 set_en,
    input  logic [OS_REG_AW-1:0] set_rd,
    input  logic                 wb_valid,
    input  logic [OS_REG_AW-1:0] wb_rd,
    output logic [OS_NREG-1:0]   sb_eff
);

    logic [OS_NREG-1:0] sb;
    logic [OS_NREG-1:0] retire_mask;
    logic [OS_NREG-1:0] set_mask;

    always_comb begin
        retire_mask = '0;
        set_mask    = '0;
        if (wb_valid) retire_mask = reg_onehot(wb_rd) & TRACK_MASK;
        if (set_en)   set_mask    = reg_onehot(set_rd) & TRACK_MASK;
    end

    assign sb_eff = sb & ~retire_mask;

    // Set is OR-ed after the clear so an issue to the retiring index wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sb <= '0;
        end else if (flush) begin
            sb <= '0;
        end else begin
            sb <= (sb_eff | set_mask) & TRACK_MASK;
        end
    end

endmodule

// File: rtl/operand_stage.sv
// ID/EX operand register with RAW/WAW scoreboard stall and valid/ready handshake.
// Optional OPERAND_STAGE_PERF_EN adds a saturating stall-cycle counter output.
module operand_stage
    import operand_stage_pkg::*;
#(
    parameter int DATA_W = OS_DATA_W,
    parameter int REG_AW = OS_REG_AW,
    parameter int CTRL_W = OS_CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] rn,
    input  logic [REG_AW-1:0] rm,
    input  logic [REG_AW-1:0] rd,
    input  logic              uses_rn,
    input  logic              uses_rm,
    input  logic              writes_rd,
    input  logic [DATA_W-1:0] rd1,
    input  logic [DATA_W-1:0] rd2,
    input  logic [CTRL_W-1:0] ctrl_in,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [DATA_W-1:0] ex_op_a,
    output logic [DATA_W-1:0] ex_op_b,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_we,
    output logic [CTRL_W-1:0] ex_ctrl,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              flush
`ifdef OPERAND_STAGE_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt
`endif
);

    logic [OS_NREG-1:0] sb_eff;
    logic               hazard;
    logic               accept;
    logic               we_eff;
    ex_bundle_t         ex_q;

    assign hazard = (uses_rn   & sb_eff[rn])
                  | (uses_rm   & sb_eff[rm])
                  | (writes_rd & sb_eff[rd]);

    assign in_ready = ~hazard & (~ex_valid | ex_ready) & ~flush;
    assign accept   = in_valid & in_ready;
    assign we_eff   = writes_rd & is_tracked(rd);

    operand_scoreboard u_sb (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .set_en   (accept & we_eff),
        .set_rd   (rd),
        .wb_valid (wb_valid),
        .wb_rd    (wb_rd),
        .sb_eff   (sb_eff)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_valid <= 1'b0;
            ex_q     <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (accept) begin
            ex_valid     <= 1'b1;
            ex_q.op_a    <= rd1;
            ex_q.op_b    <= rd2;
            ex_q.rd      <= rd;
            ex_q.we      <= we_eff;
            ex_q.ctrl    <= ctrl_in;
        end else if (ex_valid && ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

    assign ex_op_a = ex_q.op_a;
    assign ex_op_b = ex_q.op_b;
    assign ex_rd   = ex_q.rd;
    assign ex_we   = ex_q.we;
    assign ex_ctrl = ex_q.ctrl;

`ifdef OPERAND_STAGE_PERF_EN
    // Counts decode cycles lost to hazards; survives flush, saturates.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_stall_cnt <= '0;
        end else if (in_valid && hazard && !flush && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_operand_stage.sv
// Self-checking bench for operand_stage: directed plan scenarios then random traffic
// against a per-register pending-write model.
module tb_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [3:0]  rn, rm, rd;
    logic        uses_rn, uses_rm, writes_rd;
    logic [31:0] rd1, rd2;
    logic [7:0]  ctrl_in;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_op_a, ex_op_b;
    logic [3:0]  ex_rd;
    logic        ex_we;
    logic [7:0]  ex_ctrl;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic        flush;
`ifdef OPERAND_STAGE_PERF_EN
    logic [31:0] perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    operand_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .rn(rn), .rm(rm), .rd(rd),
        .uses_rn(uses_rn), .uses_rm(uses_rm), .writes_rd(writes_rd),
        .rd1(rd1), .rd2(rd2), .ctrl_in(ctrl_in),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_rd(ex_rd),
        .ex_we(ex_we), .ex_ctrl(ex_ctrl),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush)
`ifdef OPERAND_STAGE_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    // reference model
    bit          pend [16];
    bit          m_valid;
    logic [31:0] m_a, m_b;
    logic [3:0]  m_rd;
    logic        m_we;
    logic [7:0]  m_ctrl;
    longint      m_perf;
    bit          model_ok = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle();
        rst = 1; in_valid = 0; rn = 0; rm = 0; rd = 0;
        uses_rn = 0; uses_rm = 0; writes_rd = 0;
        rd1 = 0; rd2 = 0; ctrl_in = 0;
        ex_ready = 1; wb_valid = 0; wb_rd = 0; flush = 0;
    endtask

    task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                         input bit ua, input bit ub, input bit wd,
                         input logic [31:0] v1, input logic [31:0] v2);
        in_valid = 1; rn = a; rm = b; rd = d;
        uses_rn = ua; uses_rm = ub; writes_rd = wd;
        rd1 = v1; rd2 = v2; ctrl_in = 8'(v1 ^ v2);
    endtask

    function automatic bit pending_now(input logic [3:0] idx);
        // a writeback retiring this index in the current cycle hides the hazard
        return pend[idx] && !(wb_valid && wb_rd == idx);
    endfunction

    // One clock: check in_ready before the edge, update the model at the edge,
    // check the execute register after it.
    task automatic step();
        bit hz, rdy, acc, was_rst;
        #1;
        hz  = (uses_rn && pending_now(rn)) || (uses_rm && pending_now(rm)) ||
              (writes_rd && pending_now(rd));
        rdy = !hz && (!m_valid || ex_ready) && !flush;
        acc = in_valid && rdy;
        if (model_ok) check("in_ready", 32'(in_ready), 32'(rdy));
        @(posedge clk);
        was_rst = !rst;
        if (!rst) begin
            foreach (pend[i]) pend[i] = 0;
            m_valid = 0; m_a = 0; m_b = 0; m_rd = 0; m_we = 0; m_ctrl = 0; m_perf = 0;
            model_ok = 1;
        end else if (flush) begin
            foreach (pend[i]) pend[i] = 0;
            m_valid = 0;
        end else begin
            if (in_valid && hz && m_perf < 64'hFFFF_FFFF) m_perf++;
            if (wb_valid && wb_rd != 0 && wb_rd != 15) pend[wb_rd] = 0;
            if (acc) begin
                m_valid = 1; m_a = rd1; m_b = rd2; m_rd = rd; m_ctrl = ctrl_in;
                m_we = writes_rd && rd != 0 && rd != 15;
                if (m_we) pend[rd] = 1;
            end else if (m_valid && ex_ready) begin
                m_valid = 0;
            end
        end
        @(negedge clk);
        if (!model_ok) return;
        check("ex_valid", 32'(ex_valid), 32'(m_valid));
        if (m_valid || was_rst) begin
            check("ex_op_a", ex_op_a, m_a);
            check("ex_op_b", ex_op_b, m_b);
            check("ex_rd",   32'(ex_rd), 32'(m_rd));
            check("ex_we",   32'(ex_we), 32'(m_we));
            check("ex_ctrl", 32'(ex_ctrl), 32'(m_ctrl));
        end
`ifdef OPERAND_STAGE_PERF_EN
        check("perf_stall_cnt", perf_stall_cnt, 32'(m_perf));
`endif
    endtask

    initial begin
        idle();
        @(negedge clk);
        rst = 0; step(); step();
        idle();

        // plain flow
        issue(4'd1, 4'd2, 4'd3, 1, 1, 1, 32'h11, 32'h22); step();
        check("plain_op_a", ex_op_a, 32'h11);
        check("plain_we", 32'(ex_we), 32'd1);

        // RAW on r3, released by a same-cycle writeback
        idle(); issue(4'd3, 4'd0, 4'd6, 1, 0, 0, 32'h55, 32'h66);
        step(); step(); step();
        wb_valid = 1; wb_rd = 4'd3; rd1 = 32'h333; step();
        check("raw_capture", ex_op_a, 32'h333);
        idle(); step();

        // WAW on r5, then writers to PC and R0
        issue(4'd0, 4'd0, 4'd5, 0, 0, 1, 32'h5, 32'h0); step();
        idle(); issue(4'd1, 4'd1, 4'd5, 0, 0, 1, 32'h50, 32'h0); step(); step();
        wb_valid = 1; wb_rd = 4'd5; step();
        idle(); issue(4'd0, 4'd0, 4'd15, 0, 0, 1, 32'hF, 32'h0); step();
        check("pc_we", 32'(ex_we), 32'd0);
        issue(4'd0, 4'd0, 4'd0, 0, 0, 1, 32'h0, 32'h0); step();
        check("r0_we", 32'(ex_we), 32'd0);
        idle(); wb_valid = 1; wb_rd = 4'd5;
        issue(4'd15, 4'd0, 4'd0, 1, 0, 0, 32'h1F, 32'h2); step();
        idle(); step();

        // backpressure
        issue(4'd1, 4'd2, 4'd7, 1, 1, 1, 32'h70, 32'h71); step();
        issue(4'd1, 4'd2, 4'd8, 1, 1, 1, 32'h80, 32'h81); ex_ready = 0;
        step(); step(); step();
        check("bp_held", ex_op_a, 32'h70);
        ex_ready = 1; step();
        check("bp_xfer", ex_op_a, 32'h80);
        idle(); step();

        // flush mid-hazard (also three counted stall cycles when perf is built)
        rst = 0; step(); idle();
        issue(4'd0, 4'd0, 4'd4, 0, 0, 1, 32'h4, 32'h0); step();
        idle(); issue(4'd4, 4'd0, 4'd9, 1, 0, 0, 32'h44, 32'h0); step(); step(); step();
`ifdef OPERAND_STAGE_PERF_EN
        check("perf_three", perf_stall_cnt, 32'd3);
`endif
        flush = 1; step();
        flush = 0; step();
        check("post_flush", ex_op_a, 32'h44);

        // reset while busy with pending writes
        issue(4'd0, 4'd0, 4'd10, 0, 0, 1, 32'hA, 32'hB); step();
        idle(); rst = 0; step();
        check("rst_valid", 32'(ex_valid), 32'd0);
        idle(); issue(4'd10, 4'd0, 4'd0, 1, 0, 0, 32'hAA, 32'h0); step();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            idle();
            rst       = ($urandom_range(0, 199) != 0);
            in_valid  = ($urandom_range(0, 9) < 8);
            rn        = 4'($urandom_range(0, 15));
            rm        = 4'($urandom_range(0, 15));
            rd        = 4'($urandom_range(0, 15));
            uses_rn   = 1'($urandom);
            uses_rm   = 1'($urandom);
            writes_rd = ($urandom_range(0, 3) != 0);
            rd1       = $urandom;
            rd2       = $urandom;
            ctrl_in   = 8'($urandom);
            ex_ready  = ($urandom_range(0, 9) < 7);
            wb_valid  = ($urandom_range(0, 9) < 5);
            wb_rd     = 4'($urandom_range(0, 15));
            if (wb_valid && $urandom_range(0, 1) == 1)
                for (int k = 1; k < 15; k++) if (pend[k]) wb_rd = 4'(k);
            flush     = ($urandom_range(0, 39) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/operand_stage.md
Name: operand_stage

Overview:
- ID/EX boundary stage directly downstream of the register file; captures RD1/RD2 plus decoded control into the execute-stage register.
- Tracks pending destination writes in a per-register scoreboard and stalls decode on RAW/WAW hazards.
- Uses a valid/ready handshake on both sides and accepts a flush from branch resolution.

Parameters:
- DATA_W, 32, operand width (matches register file data).
- REG_AW, 4, register index width (16 architectural indices).
- CTRL_W, 8, opaque execute-control bundle width, passed through unchanged.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset (rst==0 at posedge resets).
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage accepts this cycle.
- rn  in  REG_AW  source A index (drives A1).
- rm  in  REG_AW  source B index (drives A2).
- rd  in  REG_AW  destination index.
- uses_rn, uses_rm, writes_rd  in  1 each  operand/destination qualifiers.
- rd1, rd2  in  DATA_W  register-file read data.
- ctrl_in  in  CTRL_W  execute control.
- ex_valid  out  1  execute register holds a valid instruction.
- ex_ready  in  1  execute consumes this cycle.
- ex_op_a, ex_op_b  out  DATA_W  captured operands.
- ex_rd  out  REG_AW  captured destination.
- ex_we  out  1  captured writes_rd, forced 0 for rd in {0,15}.
- ex_ctrl  out  CTRL_W  captured control.
- wb_valid  in  1  writeback retiring a register write this cycle.
- wb_rd  in  REG_AW  retiring destination.
- flush  in  1  kill execute register and clear scoreboard.

Behaviour:
- Reset: ex_valid=0, ex_op_a/ex_op_b=0, ex_rd=0, ex_we=0, ex_ctrl=0, scoreboard sb=0.
- sb: 16-bit vector. Bits 0 and 15 are hardwired 0 (R0 reads zero, R15 is PC, neither is tracked).
- Effective scoreboard: sb_eff = sb & ~retire_mask, where retire_mask = onehot(wb_rd) when wb_valid. A same-cycle retire therefore clears the hazard; the register file writes on negedge, so rd1/rd2 are correct at the capturing posedge.
- hazard = (uses_rn & sb_eff[rn]) | (uses_rm & sb_eff[rm]) | (writes_rd & sb_eff[rd]). The last term is a WAW stall.
- in_ready = ~hazard & (~ex_valid | ex_ready) & ~flush. Fully combinational, no dependency on in_valid.
- Accept = in_valid & in_ready. On accept, at the posedge:
  - ex_* <= captured inputs; ex_valid<=1.
  - if ex_we, set sb[rd].
- If ex_valid & ex_ready & ~accept: ex_valid<=0 and ex_* are held (don't-care).
- Hold: ex_valid & ~ex_ready keeps all ex_* stable; in_ready=0.
- Latency: 1 cycle from accept to ex_valid. Throughput is 1/cycle with no hazards.
- Simultaneous set and clear on the same index (issue with wb_rd==rd): set wins.
- flush (priority below reset, above everything else): ex_valid<=0, sb<=0, no accept that cycle. The issuer guarantees downstream stages are flushed in the same cycle.
- wb_valid with wb_rd in {0,15} has no effect.

Optional Feature:
- OPERAND_STAGE_PERF_EN.
- Defined: adds output perf_stall_cnt (32 bits), reset to 0. It increments every cycle with in_valid & hazard & ~flush, saturates at 0xFFFFFFFF, and is not cleared by flush.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package: the REG_PC=4'hF and REG_ZERO=4'h0 constants, and a struct typedef for the execute bundle (op_a, op_b, rd, we, ctrl).
- One natural sub-module: operand_scoreboard. It holds sb and the set/clear/flush logic, and outputs sb_eff.
- The hazard combine and the pipeline register stay in operand_stage.

Test Plan:
- Reset then plain flow: rn=1,rm=2,rd=3, rd1=0x11, rd2=0x22, in_valid=1, ex_ready=1 -> next cycle ex_valid=1, ex_op_a=0x11, ex_op_b=0x22, ex_rd=3, ex_we=1; sb[3]=1.
- RAW stall: issue rd=3, then rn=3 -> in_ready=0 until wb_valid,wb_rd=3. In the wb cycle in_ready=1 and the new rd1 is captured.
- WAW and special registers: rd=5 pending, next rd=5 -> stall. rd=15 or rd=0 writer -> ex_we=0, sb unchanged, a following rn=15 is not stalled.
- Backpressure: ex_ready=0 for 3 cycles with in_valid=1 -> ex_* stable, in_ready=0, exactly one transfer after ex_ready=1.
- Flush mid-hazard: sb[4]=1, stalled rn=4, assert flush -> ex_valid=0 and sb=0 next cycle; the same instruction is accepted the cycle after.
- Reset mid-operation: rst=0 while ex_valid=1 and sb!=0 -> all outputs and sb zero at the next posedge. With OPERAND_STAGE_PERF_EN, 3 stall cycles -> perf_stall_cnt=3.
